// File: rtl/i2s_tx.sv
// Stereo I2S master transmitter.
// Generates BCLK and LRCLK from a free-running frame counter and shifts out
// left/right words MSB first, one slot after each LRCLK edge. New samples
// land in a one-deep pending buffer and move into the transmit words at
// frame start. A frame start with nothing pending raises underrun; a second
// sample that replaces an unsent pending one raises overrun.
module i2s_tx #(
    parameter int BCLK_HALF_LOG2 = 4,
    parameter int SAMPLE_WIDTH   = 16
) (
    input  logic                    audio_clk,
    input  logic                    rst_in,
    input  logic                    sample_valid_in,
    input  logic [SAMPLE_WIDTH-1:0] left_in,
    input  logic [SAMPLE_WIDTH-1:0] right_in,
    input  logic                    mute_in,
    output logic                    bclk_out,
    output logic                    lrclk_out,
    output logic                    sdata_out,
    output logic                    frame_start_out,
    output logic                    underrun_out,
    output logic                    overrun_out
);

    // 64 slots per frame, each slot is two BCLK half-periods.
    localparam int W = BCLK_HALF_LOG2 + 7;

    logic [W-1:0]            cnt;
    logic [W-1:0]            cnt_nxt;
    logic                    wrap;
    logic [5:0]              slot_nxt;
    logic [4:0]              pos_nxt;
    logic                    slot_start_nxt;
    logic [SAMPLE_WIDTH-1:0] pend_l;
    logic [SAMPLE_WIDTH-1:0] pend_r;
    logic [SAMPLE_WIDTH-1:0] word_l;
    logic [SAMPLE_WIDTH-1:0] word_r;
    logic                    pend_full;
    logic                    missed;
    logic                    data_bit;

    // Outputs are derived from the next counter value so that they change
    // on the same edge as cnt, with no extra lag.
    assign cnt_nxt        = cnt + 1'b1;
    assign wrap           = (cnt == {W{1'b1}});
    assign slot_nxt       = cnt_nxt[W-1 -: 6];
    assign pos_nxt        = slot_nxt[4:0];
    assign slot_start_nxt = (cnt_nxt[BCLK_HALF_LOG2:0] == '0);

    // Free-running frame counter, wraps from all-ones to zero.
    always_ff @(posedge audio_clk or posedge rst_in) begin
        if (rst_in) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end

    // Select the data bit for the upcoming slot: position 1+k within a
    // half-frame carries word bit SAMPLE_WIDTH-1-k, everything else is 0.
    always_comb begin
        data_bit = 1'b0;
        for (int k = 0; k < SAMPLE_WIDTH; k++) begin
            if (pos_nxt == 5'(k + 1)) begin
                data_bit = slot_nxt[5] ? word_r[SAMPLE_WIDTH-1-k]
                                       : word_l[SAMPLE_WIDTH-1-k];
            end
        end
    end

    // Pending buffer, frame load and flow flags. A strobe on the wrap cycle
    // bypasses the buffer and goes straight into the transmit words.
    always_ff @(posedge audio_clk or posedge rst_in) begin
        if (rst_in) begin
            pend_l      <= '0;
            pend_r      <= '0;
            pend_full   <= 1'b0;
            word_l      <= '0;
            word_r      <= '0;
            missed      <= 1'b0;
            overrun_out <= 1'b0;
        end else begin
            overrun_out <= sample_valid_in && pend_full && !wrap;
            if (wrap) begin
                pend_full <= 1'b0;
                if (sample_valid_in) begin
                    word_l <= left_in;
                    word_r <= right_in;
                    missed <= 1'b0;
                end else if (pend_full) begin
                    word_l <= pend_l;
                    word_r <= pend_r;
                    missed <= 1'b0;
                end else begin
                    missed <= 1'b1;
                end
            end else if (sample_valid_in) begin
                pend_l    <= left_in;
                pend_r    <= right_in;
                pend_full <= 1'b1;
            end
        end
    end

    // Registered I2S pins and status pulses. Serial data and mute are only
    // taken at slot boundaries so sdata is stable around each BCLK rise.
    always_ff @(posedge audio_clk or posedge rst_in) begin
        if (rst_in) begin
            bclk_out        <= 1'b0;
            lrclk_out       <= 1'b0;
            sdata_out       <= 1'b0;
            frame_start_out <= 1'b0;
            underrun_out    <= 1'b0;
        end else begin
            bclk_out        <= cnt_nxt[BCLK_HALF_LOG2];
            lrclk_out       <= cnt_nxt[W-1];
            frame_start_out <= (cnt_nxt == '0);
            underrun_out    <= missed && (cnt_nxt == W'(1));
            if (slot_start_nxt) begin
                sdata_out <= data_bit && !mute_in;
            end
        end
    end

endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx at default parameters (16-bit words, 2048-cycle frame).
module tb_i2s_tx;

    localparam int F  = 2048;
    localparam int SL = 32;
    localparam int HP = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        v   = 1'b0;
    logic        m   = 1'b0;
    logic [15:0] l   = '0;
    logic [15:0] r   = '0;
    logic        bclk, lrclk, sd, fs, und, ovr;

    i2s_tx dut (
        .audio_clk       (clk),
        .rst_in          (rst),
        .sample_valid_in (v),
        .left_in         (l),
        .right_in        (r),
        .mute_in         (m),
        .bclk_out        (bclk),
        .lrclk_out       (lrclk),
        .sdata_out       (sd),
        .frame_start_out (fs),
        .underrun_out    (und),
        .overrun_out     (ovr)
    );

    // Clock: 10 time units per audio_clk cycle.
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: frame position, pending sample, words on air.
    int          mc;
    logic        pf;
    logic [15:0] pl, pr, wl, wr;
    logic        miss;
    logic        e_sd;
    logic        e_ovr;
    logic [63:0] cap;
    logic [63:0] last_frame;
    int          und_cnt, ovr_cnt;
    int          tick_n, bclk_rise, bclk_per, lr_rise, lr_per;
    logic        prev_b, prev_lr;

    typedef struct {
        int          v1;
        logic [15:0] l1;
        logic [15:0] r1;
        int          v2;
        logic [15:0] l2;
        logic [15:0] r2;
        logic        mute;
        logic [63:0] exp_frame;
        int          exp_und;
        int          exp_ovr;
    } row_t;

    row_t rows[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 20)
                $display("FAIL %s: got %h expected %h (t=%0t cnt=%0d)", name, act, exp, $time, mc);
        end
    endtask

    // One I2S frame as 64 slot bits, slot 0 at the MSB.
    function automatic logic frame_bit(input int s, input logic [15:0] a, input logic [15:0] b);
        logic [63:0] f;
        f = {1'b0, a, 16'h0, b, 15'h0};
        return f[63 - s];
    endfunction

    task automatic model_reset();
        mc = 0; pf = 0; pl = '0; pr = '0; wl = '0; wr = '0;
        miss = 0; e_sd = 0; e_ovr = 0;
        prev_b = 0; prev_lr = 0;
        bclk_rise = -1; lr_rise = -1; bclk_per = 0; lr_per = 0;
        und_cnt = 0; ovr_cnt = 0; cap = '0; last_frame = '0;
    endtask

    // Advance one clock, update the reference, compare all outputs.
    task automatic tick();
        logic [5:0] exp_v;
        @(posedge clk);
        e_ovr = v && pf && (mc != F - 1);
        mc = (mc + 1) % F;
        if (mc == 0) begin
            if (v) begin
                wl = l; wr = r; miss = 0;
            end else if (pf) begin
                wl = pl; wr = pr; miss = 0;
            end else begin
                miss = 1;
            end
            pf = 0;
        end else if (v) begin
            pl = l; pr = r; pf = 1;
        end
        if (mc % SL == 0)
            e_sd = m ? 1'b0 : frame_bit(mc / SL, wl, wr);
        tick_n++;
        #1;
        exp_v = {((mc / HP) % 2) == 1, mc >= F / 2, e_sd, mc == 0, (mc == 1) && miss, e_ovr};
        check("outputs", 64'({bclk, lrclk, sd, fs, und, ovr}), 64'(exp_v));
        if (und) und_cnt++;
        if (ovr) ovr_cnt++;
        if (mc % SL == HP) cap[63 - mc / SL] = sd;
        if (mc == F - 1) last_frame = cap;
        if (bclk && !prev_b) begin
            if (bclk_rise >= 0) bclk_per = tick_n - bclk_rise;
            bclk_rise = tick_n;
        end
        if (lrclk && !prev_lr) begin
            if (lr_rise >= 0) lr_per = tick_n - lr_rise;
            lr_rise = tick_n;
        end
        prev_b  = bclk;
        prev_lr = lrclk;
    endtask

    // Tick at least once, then until the counter reaches target.
    task automatic run_until(input int target);
        int guard;
        guard = 0;
        do begin
            tick();
            guard++;
        end while (mc != target && guard < 3 * F);
        if (mc != target) begin
            n_checks++;
            n_fail++;
            $display("FAIL run_until: got cnt %0d expected %0d", mc, target);
        end
    endtask

    task automatic pulse(input logic [15:0] a, input logic [15:0] b);
        v = 1'b1; l = a; r = b;
        tick();
        v = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rows[0] = '{100, 16'hA5C3, 16'h0F0F, -1, 16'h0, 16'h0, 1'b0,
                    {1'b0, 16'hA5C3, 16'h0, 16'h0F0F, 15'h0}, 0, 0};
        rows[1] = '{-1, 16'h0, 16'h0, -1, 16'h0, 16'h0, 1'b0,
                    {1'b0, 16'hA5C3, 16'h0, 16'h0F0F, 15'h0}, 1, 0};
        rows[2] = '{100, 16'h1111, 16'h1111, 200, 16'h2222, 16'h2222, 1'b0,
                    {1'b0, 16'h2222, 16'h0, 16'h2222, 15'h0}, 0, 1};
        rows[3] = '{F - 1, 16'h8001, 16'h8001, -1, 16'h0, 16'h0, 1'b0,
                    {1'b0, 16'h8001, 16'h0, 16'h8001, 15'h0}, 0, 0};
        rows[4] = '{100, 16'hA5C3, 16'h0F0F, -1, 16'h0, 16'h0, 1'b1,
                    64'h0, 0, 0};

        // Power-on reset.
        tick_n = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", 64'({bclk, lrclk, sd, fs, und, ovr}), 64'(0));
        @(negedge clk);
        rst = 1'b0;

        // First frame after reset: zeros, no underrun.
        run_until(F - 1);
        check("first_frame_zero", last_frame, 64'h0);
        check("first_frame_underrun", 64'(und_cnt), 64'(0));

        // Frame patterns.
        for (int i = 0; i < 5; i++) begin
            run_until(F - 1);
            und_cnt = 0;
            ovr_cnt = 0;
            if (rows[i].v1 >= 0) begin
                run_until(rows[i].v1);
                und_cnt = 0;
                ovr_cnt = 0;
                pulse(rows[i].l1, rows[i].r1);
            end
            if (rows[i].v2 >= 0) begin
                run_until(rows[i].v2);
                pulse(rows[i].l2, rows[i].r2);
            end
            if (rows[i].v1 >= 0 && mc != 0) run_until(F - 1);
            m = rows[i].mute;
            run_until(F - 1);
            m = 1'b0;
            check($sformatf("row%0d_frame", i), last_frame, rows[i].exp_frame);
            check($sformatf("row%0d_underrun", i), 64'(und_cnt), 64'(rows[i].exp_und));
            check($sformatf("row%0d_overrun", i), 64'(ovr_cnt), 64'(rows[i].exp_ovr));
        end

        // Mute released mid-frame takes effect at the next slot boundary.
        run_until(100);
        m = 1'b1;
        pulse(16'hA5C3, 16'h0F0F);
        run_until(F - 1);
        run_until(300);
        m = 1'b0;
        run_until(310);
        check("mute_hold_slot9", 64'(sd), 64'(0));
        run_until(325);
        check("mute_release_slot10", 64'(sd), 64'(1));

        // Asynchronous reset in the high half of a right-channel slot.
        run_until(1300);
        check("pre_reset_clocks", 64'({bclk, lrclk}), 64'(2'b11));
        #3;
        rst = 1'b1;
        #1;
        check("async_reset_outputs", 64'({bclk, lrclk, sd, fs, und, ovr}), 64'(0));
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        run_until(F - 1);
        check("post_reset_underrun", 64'(und_cnt), 64'(0));
        check("post_reset_frame_zero", last_frame, 64'h0);
        run_until(1100);
        check("bclk_period", 64'(bclk_per), 64'(32));
        check("lrclk_period", 64'(lr_per), 64'(2048));

        // Randomised traffic and mute toggling.
        repeat (8 * F) begin
            v = ($urandom_range(0, 499) == 0);
            l = 16'($urandom);
            r = 16'($urandom);
            if ($urandom_range(0, 699) == 0) m = ~m;
            tick();
        end
        v = 1'b0;
        m = 1'b0;
        for (int i = 0; i < 3; i++) begin
            run_until(F - 1 - $urandom_range(0, 1));
            pulse(16'($urandom), 16'($urandom));
        end
        run_until(F - 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
